dct_frame_sched: RTL
====================

# dct_frame_sched

Frame scheduler and sequencer for the DCT post-FFT scaling datapath. Per-frame transform sizes are queued from the control side. The block frames the raw FFT output sample stream into exactly N-sample frames with sop/eop. Each beat carries the matching fftpts and scaling shift code, so the downstream scaling stage always sees consistent per-frame configuration. Unsupported sizes are rejected.

## Interface
Parameters:
- wData, 48, width of sink/source real and imag samples
- CFG_DEPTH, 4, config FIFO depth (power of 2)

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset; one clock; reset is asynchronous and active-low
- cfg_valid  in  1  config word offered
- cfg_ready  out  1  config FIFO not full
- cfg_fftpts  in  12  transform size for one frame
- sink_valid  in  1  input sample valid
- sink_ready  out  1  input sample accepted when high with sink_valid
- sink_real, sink_imag  in  wData  input sample
- source_valid  out  1  output beat valid
- source_ready  in  1  downstream accepts beat
- source_sop, source_eop  out  1  first / last beat of frame
- source_real, source_imag  out  wData  registered sample
- fftpts_out  out  12  size of frame this beat belongs to
- shift_out  out  2  scaling shift code for this beat
- cfg_err  out  1  one-cycle pulse: unsupported size dropped
- frame_done  out  1  one-cycle pulse: eop beat handshaken on source
- frame_cnt  out  16  completed frames, wraps 0xFFFF->0
- busy  out  1  state != IDLE or source_valid

## Operation
- Supported sizes and shift codes: 2048/1024 -> 0; 512/256 -> 1; 128/64 -> 2. Code 3 is reserved and never emitted. Any other size is unsupported.
- Config FIFO: push on cfg_valid & cfg_ready. cfg_ready = !full, evaluated from current occupancy. Push-while-pop on a full FIFO is not accepted. Occurs in the same cycle as a pop otherwise.
- FSM states:
  - IDLE: if FIFO non-empty, pop and go to LOAD.
  - LOAD: latch size and shift into frame registers and clear the sample counter. If size is unsupported, pulse cfg_err and return to IDLE; no beats are emitted. Otherwise go to RUN.
  - RUN: accept samples. Counter cnt (11 bits) increments per accepted sample. The sample with cnt==0 is tagged sop. The sample with cnt==N-1 is tagged eop; on that acceptance go to IDLE.
- sink_ready = (state==RUN) & (!source_valid | source_ready). It is 0 in IDLE and LOAD.
- Output register, one deep:
  - On sink accept, it loads data, sop, eop, fftpts_out, shift_out and sets source_valid.
  - On source handshake without a new accept, it clears source_valid.
  - Tags belong to the beat, so the next frame's LOAD never alters an in-flight beat.
- On handshake of an eop beat: pulse frame_done and increment frame_cnt.
- Stalls: while source_valid & !source_ready, all output fields hold stable.

## Timing
- Reset values: cfg_ready=1 (FIFO empty), sink_ready=0, source_valid=0, sop=0, eop=0, real/imag=0, fftpts_out=0, shift_out=0, cfg_err=0, frame_done=0, frame_cnt=0, busy=0, state=IDLE.
- Reset asserted mid-frame: everything is cleared immediately, FIFO contents are discarded, and no partial eop is emitted.
- Latency: a config word pushed in cycle t is popped at t+1 (IDLE), is in LOAD at t+2, and sink_ready may rise at t+3.
- Sample accepted in cycle t appears on source at t+1.
- Frame gap: eop accepted at t -> IDLE at t+1 -> LOAD at t+2 -> RUN at t+3. That is 2 sink bubble cycles between back-to-back frames.
- Full throughput inside a frame is 1 sample/cycle when source_ready is held high.

## Structure
- Shared package dct_pkg holds:
  - supported-size constants
  - shift-code encoding (SHIFT_2048 etc.)
  - state enum IDLE/LOAD/RUN
  - a function mapping size to {supported, shift}, shared with the scaling stage
- One sub-module: dct_cfg_fifo, a synchronous FIFO, width 12, depth CFG_DEPTH, with full/empty outputs and async active-low reset.

## Test plan
- Push 64, stream 64 samples with source_ready=1 -> 64 beats. sop on beat 0, eop on beat 63, shift_out=2, fftpts_out=64, one frame_done, frame_cnt=1.
- Push 2048 then 512 back-to-back -> first frame beats carry shift 0 and the second carry shift 1. Exactly 2 sink_ready-low cycles between frames, and the last beat of frame 1 keeps fftpts_out=2048.
- Push 100 then 256 -> cfg_err pulses once with no beats for 100. The 256 frame runs normally with shift 1, and frame_cnt=1.
- Toggle source_ready randomly during a 128 frame -> output fields are stable while stalled, no sample is lost or duplicated, and exactly 128 beats are emitted.
- Push 5 configs with CFG_DEPTH=4 while the FSM is in RUN -> cfg_ready=0 after the fourth push and the fifth is held off. Drain the frames and check that all 5 sizes run in order.
- Assert rst_n low at sample 30 of a 1024 frame -> all outputs return to reset values asynchronously. After release, a new 64 frame starts cleanly with sop.

Source files
------------

// File: rtl/dct_pkg.sv
// Shared definitions for the DCT post-FFT scaling path: supported transform
// sizes, scaling shift encoding, scheduler states and the size decoder.
package dct_pkg;

  localparam logic [11:0] SIZE_2048 = 12'd2048;
  localparam logic [11:0] SIZE_1024 = 12'd1024;
  localparam logic [11:0] SIZE_512  = 12'd512;
  localparam logic [11:0] SIZE_256  = 12'd256;
  localparam logic [11:0] SIZE_128  = 12'd128;
  localparam logic [11:0] SIZE_64   = 12'd64;

  // Scaling shift codes; code 3 is reserved and never produced.
  localparam logic [1:0] SHIFT_2048 = 2'd0;
  localparam logic [1:0] SHIFT_1024 = 2'd0;
  localparam logic [1:0] SHIFT_512  = 2'd1;
  localparam logic [1:0] SHIFT_256  = 2'd1;
  localparam logic [1:0] SHIFT_128  = 2'd2;
  localparam logic [1:0] SHIFT_64   = 2'd2;
  localparam logic [1:0] SHIFT_RSVD = 2'd3;

  // Scheduler states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  typedef struct packed {
    logic       supported;
    logic [1:0] shift;
  } size_cfg_t;

  // Decode a transform size into {supported, shift}. Unsupported sizes
  // return shift 0 so nothing reserved can leak downstream.
  function automatic size_cfg_t size_to_cfg(input logic [11:0] size);
    size_cfg_t c;
    c.supported = 1'b0;
    c.shift     = 2'd0;
    case (size)
      SIZE_2048: begin c.supported = 1'b1; c.shift = SHIFT_2048; end
      SIZE_1024: begin c.supported = 1'b1; c.shift = SHIFT_1024; end
      SIZE_512:  begin c.supported = 1'b1; c.shift = SHIFT_512;  end
      SIZE_256:  begin c.supported = 1'b1; c.shift = SHIFT_256;  end
      SIZE_128:  begin c.supported = 1'b1; c.shift = SHIFT_128;  end
      SIZE_64:   begin c.supported = 1'b1; c.shift = SHIFT_64;   end
      default:   begin c.supported = 1'b0; c.shift = 2'd0;       end
    endcase
    return c;
  endfunction

endpackage

// File: rtl/dct_cfg_fifo.sv
// Small synchronous FIFO holding queued per-frame transform sizes.
// A push offered while full is refused even if a pop happens that cycle.
module dct_cfg_fifo
  import dct_pkg::*;
#(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             push_s;
  logic             pop_s;

  assign full    = (count_r == (AW+1)'(DEPTH));
  assign empty   = (count_r == '0);
  assign push_s  = push & ~full;
  assign pop_s   = pop & ~empty;
  assign rd_data = mem_r[rd_ptr_r];

  // Storage array: written on accepted push, no reset needed for data
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/dct_frame_sched.sv
// Frames the raw FFT sample stream into N-sample frames, tagging every beat
// with the frame's size and scaling shift code so the scaling stage always
// sees a consistent configuration. Unsupported sizes are dropped with cfg_err.
module dct_frame_sched
  import dct_pkg::*;
#(
  parameter int wData     = 48,
  parameter int CFG_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [11:0]      cfg_fftpts,
  input  logic             sink_valid,
  output logic             sink_ready,
  input  logic [wData-1:0] sink_real,
  input  logic [wData-1:0] sink_imag,
  output logic             source_valid,
  input  logic             source_ready,
  output logic             source_sop,
  output logic             source_eop,
  output logic [wData-1:0] source_real,
  output logic [wData-1:0] source_imag,
  output logic [11:0]      fftpts_out,
  output logic [1:0]       shift_out,
  output logic             cfg_err,
  output logic             frame_done,
  output logic [15:0]      frame_cnt,
  output logic             busy
);

  logic [1:0]       state_r;
  logic [11:0]      cfg_word_r;
  logic [11:0]      frame_size_r;
  logic [1:0]       frame_shift_r;
  logic [10:0]      cnt_r;

  logic             src_valid_r;
  logic             src_sop_r;
  logic             src_eop_r;
  logic [wData-1:0] src_real_r;
  logic [wData-1:0] src_imag_r;
  logic [11:0]      src_fft_r;
  logic [1:0]       src_shift_r;
  logic             cfg_err_r;
  logic             frame_done_r;
  logic [15:0]      frame_cnt_r;

  logic             fifo_full_s;
  logic             fifo_empty_s;
  logic [11:0]      fifo_rd_data_s;
  logic             fifo_pop_s;
  size_cfg_t        load_cfg_s;
  logic             sink_ready_s;
  logic             sink_acc_s;
  logic             src_hs_s;
  logic             last_s;

  assign fifo_pop_s   = (state_r == ST_IDLE) & ~fifo_empty_s;
  assign load_cfg_s   = size_to_cfg(cfg_word_r);
  assign sink_ready_s = (state_r == ST_RUN) & (~src_valid_r | source_ready);
  assign sink_acc_s   = sink_valid & sink_ready_s;
  assign src_hs_s     = src_valid_r & source_ready;
  assign last_s       = ({1'b0, cnt_r} == (frame_size_r - 12'd1));

  dct_cfg_fifo #(
    .WIDTH (12),
    .DEPTH (CFG_DEPTH)
  ) u_cfg_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (cfg_valid),
    .wr_data (cfg_fftpts),
    .pop     (fifo_pop_s),
    .rd_data (fifo_rd_data_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s)
  );

  // Frame sequencer: pop a size, latch its configuration, count samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      cfg_word_r    <= 12'd0;
      frame_size_r  <= 12'd0;
      frame_shift_r <= 2'd0;
      cnt_r         <= 11'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (!fifo_empty_s) begin
            cfg_word_r <= fifo_rd_data_s;
            state_r    <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          frame_size_r  <= cfg_word_r;
          frame_shift_r <= load_cfg_s.shift;
          cnt_r         <= 11'd0;
          state_r       <= load_cfg_s.supported ? ST_RUN : ST_IDLE;
        end
        ST_RUN: begin
          if (sink_acc_s) begin
            cnt_r <= cnt_r + 11'd1;
            if (last_s) begin
              state_r <= ST_IDLE;
            end
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // Unsupported-size pulse, raised the cycle after LOAD sees a bad size
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_err_r <= 1'b0;
    end else begin
      cfg_err_r <= (state_r == ST_LOAD) & ~load_cfg_s.supported;
    end
  end

  // One-deep output register; tags travel with the beat they were captured with
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_valid_r <= 1'b0;
      src_sop_r   <= 1'b0;
      src_eop_r   <= 1'b0;
      src_real_r  <= '0;
      src_imag_r  <= '0;
      src_fft_r   <= 12'd0;
      src_shift_r <= 2'd0;
    end else if (sink_acc_s) begin
      src_valid_r <= 1'b1;
      src_sop_r   <= (cnt_r == 11'd0);
      src_eop_r   <= last_s;
      src_real_r  <= sink_real;
      src_imag_r  <= sink_imag;
      src_fft_r   <= frame_size_r;
      src_shift_r <= frame_shift_r;
    end else if (src_hs_s) begin
      src_valid_r <= 1'b0;
    end
  end

  // Completed-frame pulse and wrapping frame counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_done_r <= 1'b0;
      frame_cnt_r  <= 16'd0;
    end else begin
      frame_done_r <= src_hs_s & src_eop_r;
      if (src_hs_s & src_eop_r) begin
        frame_cnt_r <= frame_cnt_r + 16'd1;
      end
    end
  end

  assign cfg_ready    = ~fifo_full_s;
  assign sink_ready   = sink_ready_s;
  assign source_valid = src_valid_r;
  assign source_sop   = src_sop_r;
  assign source_eop   = src_eop_r;
  assign source_real  = src_real_r;
  assign source_imag  = src_imag_r;
  assign fftpts_out   = src_fft_r;
  assign shift_out    = src_shift_r;
  assign cfg_err      = cfg_err_r;
  assign frame_done   = frame_done_r;
  assign frame_cnt    = frame_cnt_r;
  assign busy         = (state_r != ST_IDLE) | src_valid_r;

endmodule
